// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MIPS32 load/store unit in front of a word-organised data memory
// Byte/half/word loads and stores, read-modify-write for sub-word stores, error on misaligned/out-of-range.
module lsu_mem_ctrl #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wr_data,
    input  logic [DWIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              rd_phase_q;
    logic [DWIDTH-1:0] rword_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              mem_rd_en_q;
    logic              mem_wr_en_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wr_data_q;

    logic              acc_err;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    always_comb begin
        acc_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0] != 1'b0)
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_addr[31:AWIDTH+2] != '0);

        case (lane_q)
            2'd0:    sel_byte = rword_q[7:0];
            2'd1:    sel_byte = rword_q[15:8];
            2'd2:    sel_byte = rword_q[23:16];
            default: sel_byte = rword_q[31:24];
        endcase
        sel_half = lane_q[1] ? rword_q[31:16] : rword_q[15:0];

        case (size_q)
            2'b00:   load_val = {{24{~uns_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{~uns_q & sel_half[15]}}, sel_half};
            default: load_val = rword_q;
        endcase

        // Only the addressed lanes change; the rest of the read word passes through untouched.
        merged = rword_q;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            lane_q        <= 2'b00;
            wdata_q       <= '0;
            rd_phase_q    <= 1'b0;
            rword_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q         <= req_we;
                        size_q       <= req_size;
                        uns_q        <= req_unsigned;
                        lane_q       <= req_addr[1:0];
                        wdata_q      <= req_wdata[15:0];
                        mem_addr_q   <= req_addr[AWIDTH+1:2];
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= '0;
                        if (acc_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_we && req_size == 2'b10) begin
                            state_q       <= S_WRITE;
                            mem_wr_en_q   <= 1'b1;
                            mem_wr_data_q <= req_wdata;
                        end else begin
                            state_q     <= S_READ;
                            mem_rd_en_q <= 1'b1;
                            rd_phase_q  <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    // First cycle latches the raw word; second cycle extracts or merges from it.
                    if (!rd_phase_q) begin
                        rword_q    <= mem_rd_data;
                        rd_phase_q <= 1'b1;
                    end else if (we_q) begin
                        state_q       <= S_WRITE;
                        mem_wr_en_q   <= 1'b1;
                        mem_wr_data_q <= merged;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_val;
                    end
                end
                S_WRITE: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed and random checks of lsu_mem_ctrl against a word-array model
module tb_lsu_mem_ctrl;
    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    int n_chk  = 0;
    int n_fail = 0;
    int acc_cnt = 0;

    lsu_mem_ctrl #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Data memory: samples on the negedge.
    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (rstn && req_valid && req_ready) acc_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        logic        err;
        int          elat, erd, ewr, widx, sh;
        logic [31:0] old, exp_rd, exp_wd, mask, b;
        int          lat, rdc, wrc, both, rdy;
        logic        got_err;
        logic [31:0] got_rd, got_wa, got_wd;

        err  = (sz == 2'b11) || (sz == 2'b01 && addr % 2 != 0) ||
               (sz == 2'b10 && addr % 4 != 0) || (addr >= 32'(4 * NW));
        widx = int'((addr / 4) % NW);
        sh   = 8 * int'(addr % 4);
        old  = ref_mem[widx];
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        erd = 0;
        ewr = 0;
        if (err) begin
            elat = 1;
        end else if (we) begin
            ewr = 1;
            if (sz == 2'b10) begin
                elat   = 2;
                exp_wd = wd;
            end else begin
                elat   = 4;
                erd    = 1;
                mask   = (sz == 2'b00 ? 32'hFF : 32'hFFFF) << sh;
                exp_wd = (old & ~mask) | ((wd << sh) & mask);
            end
            ref_mem[widx] = exp_wd;
        end else begin
            elat = 3;
            erd  = 1;
            if (sz == 2'b10) begin
                exp_rd = old;
            end else if (sz == 2'b00) begin
                b = (old >> sh) & 32'hFF;
                exp_rd = (!uns && b >= 128) ? b + 32'hFFFFFF00 : b;
            end else begin
                b = (old >> sh) & 32'hFFFF;
                exp_rd = (!uns && b >= 32768) ? b + 32'hFFFF0000 : b;
            end
        end

        @(negedge clk);
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'h1);
        chk("resp_idle_low", {31'b0, resp_valid}, 32'h0);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;

        lat = 0; rdc = 0; wrc = 0; both = 0; rdy = 0;
        got_err = 1'b0; got_rd = 32'h0; got_wa = 32'h0; got_wd = 32'h0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_rd_en) rdc++;
            if (mem_wr_en) begin
                wrc++;
                got_wa = 32'(mem_addr);
                got_wd = mem_wr_data;
            end
            if (mem_rd_en && mem_wr_en) both++;
            if (req_ready) rdy++;
            if (resp_valid) begin
                lat     = k;
                got_err = resp_err;
                got_rd  = resp_rdata;
            end
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("resp_err", {31'b0, got_err}, {31'b0, err});
        chk("resp_rdata", got_rd, exp_rd);
        chk("rd_pulses", 32'(rdc), 32'(erd));
        chk("wr_pulses", 32'(wrc), 32'(ewr));
        chk("rd_wr_overlap", 32'(both), 32'h0);
        chk("ready_low_busy", 32'(rdy), 32'h0);
        if (ewr == 1) begin
            chk("wr_addr", got_wa, 32'(widx));
            chk("wr_data", got_wd, exp_wd);
        end
    endtask

    initial begin
        logic [31:0] v, a, d;
        logic [1:0]  s;
        int          r, acc0, wrs, rsp;

        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            mem[i]     <= v;
            ref_mem[i]  = v;
        end
        rstn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {30'b0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        rstn = 1'b1;

        // Directed word, sub-word and error cases.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA5555, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h00001000, 32'h0, 1'b0);

        // Reset while a sub-word store is in READ: the write must never appear.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h21; req_wdata = 32'h000000A5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("midrst_mem_en", {30'b0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("midrst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wrs = 0; rsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_wr_en) wrs++;
            if (resp_valid) rsp++;
        end
        chk("midrst_no_write", 32'(wrs), 32'h0);
        chk("midrst_no_resp", 32'(rsp), 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // req_valid held high across alternating SW/LW transactions.
        acc0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, 63)) * 4;
            do_req(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1);
            do_req(1'b0, 2'b10, 1'b0, a, 32'h0, 1'b1);
        end
        req_valid = 1'b0;
        chk("held_accept_count", 32'(acc_cnt - acc0), 32'd12);

        // Random mix over a small address window plus occasional wild addresses.
        for (int i = 0; i < 60; i++) begin
            s = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else a = 32'($urandom_range(0, 63));
            if (r >= 4 && s == 2'b01) a = a & ~32'h1;
            if (r >= 4 && s == 2'b10) a = a & ~32'h3;
            d = $urandom;
            do_req(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, d, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the MIPS32 MEM pipeline stage and the word-organised data memory (ISDATA=1 instance).
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word reads and writes.
- Performs read-modify-write for sub-word stores, and sign/zero extension for sub-word loads.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- AWIDTH, 10, data memory word-address width; memory holds 2**AWIDTH words.
- DWIDTH, 32, memory data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready at posedge
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and LW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; access rejected
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_rd_en  out  1  to memory rd_en
- mem_wr_en  out  1  to memory wr_en
- mem_addr  out  AWIDTH  word address = captured addr[AWIDTH+1:2]
- mem_wr_data  out  DWIDTH  to memory wr_data
- mem_rd_data  in  DWIDTH  from memory rd_data

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1.
- Capture registers clear to 0.
- Reset mid-operation abandons the access; no pending write is issued after reset release.
- States are IDLE, READ, WRITE, RESP (Moore).
- All mem_* outputs and resp_* outputs come from registers/state only.
- There is no combinational path from req_* to any output, so mem_* are stable across the memory's negedge sampling.
- IDLE:
  - req_ready=1.
  - On accept, capture we, size, unsigned, addr, wdata.
  - Error if: size==11; size==01 and addr[0]!=0; size==10 and addr[1:0]!=0; or addr[31:AWIDTH+2]!=0. On error go to RESP with resp_err=1 and no memory access.
  - Otherwise: store word goes to WRITE; every load and every sub-word store goes to READ.
- READ:
  - mem_rd_en=1 and mem_addr driven for exactly one cycle.
  - The memory samples on the mid-cycle negedge, so mem_rd_data is valid at the posedge ending READ.
  - Load: register the extracted/extended value into resp_rdata, then go to RESP.
  - Sub-word store: register the merged word into mem_wr_data, then go to WRITE.
- WRITE: mem_wr_en=1 for exactly one cycle, with mem_addr and mem_wr_data held; next state RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; next state IDLE. The consumer must take the pulse (no backpressure).
- Lane mapping is little-endian:
  - addr[1:0]=n selects byte bits [8n+7:8n].
  - addr[1]=h selects half bits [16h+15:16h].
- Loads: sign-extend from bit 7/15 unless unsigned, in which case zero-extend. LW returns the word unchanged.
- Merge: replace only the selected byte/half lanes of the read word with wdata[7:0]/[15:0]; other lanes are preserved bit-exact.
- Latency from the accept posedge T until resp_valid is high:
  - error: T+1
  - SW: T+2
  - load: T+3
  - SB/SH: T+4
- Back-to-back: the next request can be accepted in the cycle after RESP.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> exactly one mem_wr_en pulse at mem_addr=4 with 0xDEADBEEF; LW resp_rdata=0xDEADBEEF, resp_err=0, at latencies 2 and 3.
- After word 0xDEADBEEF at 0x10: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata 0x12345677 over 0xDEADBEEF -> mem_rd_en pulse, then mem_wr_data=0xDEAD77EF; SH 0x12 wdata 0xAAAA5555 -> 0x555577EF.
- LH 0x01, LW 0x02, size 11, and LW 0x00001000 (AWIDTH=10) -> each gives resp_err=1, resp_rdata=0 one cycle after accept; no mem_rd_en/mem_wr_en pulse.
- SB accepted, rstn pulsed low during READ -> outputs at reset values, req_ready=1, no mem_wr_en after release; next LW completes normally.
- Hold req_valid high continuously with alternating SW/LW -> one accept per transaction, req_ready low from accept through RESP, no request dropped or duplicated.
